avl_fb_read_check: RTL

Avalon-MM read master that reads the frame buffer back from DDR after the test-pattern fill and checks each word against the same four-band colour pattern. It sits on the same Avalon-MM port as the fill writer. The two blocks are never active at once; this block starts only after the fill reports complete. It issues pipelined single-word reads with a bounded number of outstanding requests, compares the returned data in order, and reports pass/fail plus an error count.

---
 rtl/avl_fb_read_check.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/avl_fb_read_check.sv
// Avalon-MM frame-buffer read-back checker for the four-band test pattern.
// Optional first-error capture ports are enabled with FB_CHECK_CAPTURE_EN.
module avl_fb_read_check #(
    parameter int                ADDR_W      = 27,
    parameter int                DATA_W      = 32,
    parameter int                FRAME_WORDS = 2073600,
    parameter int                MAX_PEND    = 4,
    parameter logic [DATA_W-1:0] DATA_MASK   = 32'h00FFFFFF,
    parameter int                BAND0_LAST  = 32'h7E900,
    parameter int                BAND1_LAST  = 32'hFD200,
    parameter int                BAND2_LAST  = 32'h17BB00
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic              local_init_done,
    input  logic              avl_waitrequest_n,
    output logic [ADDR_W-1:0] avl_address,
    output logic              avl_read,
    output logic              avl_burstbegin,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_readdatavalid,
    output logic              drv_status_test_complete,
    output logic              drv_status_pass,
    output logic [31:0]       err_count,
`ifdef FB_CHECK_CAPTURE_EN
    output logic              first_err_valid,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
`endif
    output logic [1:0]        c_state
);

    localparam int PW = 4;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [PW-1:0]     PEND_MAX  = PW'(MAX_PEND);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        hist_q, hist_d;
    logic              trig_q, trig_d;
    logic              rd_q, rd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PW-1:0]     pend_q, pend_d, pend_nx;
    logic [ADDR_W-1:0] chk_q, chk_d;
    logic [31:0]       err_q, err_d;

`ifdef FB_CHECK_CAPTURE_EN
    logic              fe_v_q, fe_v_d;
    logic [ADDR_W-1:0] fe_a_q, fe_a_d;
    logic [DATA_W-1:0] fe_dat_q, fe_dat_d;
`endif

    logic              active;
    logic              accept;
    logic              rvalid;
    logic              mismatch;
    logic              start;
    logic [DATA_W-1:0] expected;

    function automatic logic [DATA_W-1:0] band_px(input logic [ADDR_W-1:0] a);
        if (a <= ADDR_W'(BAND0_LAST))
            return DATA_W'(32'h00FF0000);
        else if (a <= ADDR_W'(BAND1_LAST))
            return DATA_W'(32'h0000FF00);
        else if (a <= ADDR_W'(BAND2_LAST))
            return DATA_W'(32'h000000FF);
        else
            return DATA_W'(32'h00FFFFFF);
    endfunction

    always_comb begin
        hist_d   = {hist_q[0], iSTART};
        trig_d   = hist_q[1] & ~hist_q[0];
        active   = (state_q == ISSUE) || (state_q == DRAIN);
        accept   = rd_q & avl_waitrequest_n;
        // Stray data with nothing outstanding must not underflow pending
        rvalid   = avl_readdatavalid & active & (pend_q != '0);
        expected = band_px(chk_q);
        mismatch = |((avl_readdata ^ expected) & DATA_MASK);
        start    = trig_q & local_init_done &
                   ((state_q == IDLE) || (state_q == DONE));

        unique case ({accept, rvalid})
            2'b10:   pend_nx = pend_q + PW'(1);
            2'b01:   pend_nx = pend_q - PW'(1);
            default: pend_nx = pend_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        pend_d  = pend_nx;
        chk_d   = chk_q;
        err_d   = err_q;

        if (rvalid) begin
            chk_d = chk_q + ADDR_W'(1);
            if (mismatch && (err_q != 32'hFFFFFFFF))
                err_d = err_q + 32'd1;
        end

        if (accept)
            addr_d = addr_q + ADDR_W'(1);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = ISSUE;
                    rd_d    = 1'b1;
                    addr_d  = '0;
                    pend_d  = '0;
                    chk_d   = '0;
                    err_d   = '0;
                end
            end
            ISSUE: begin
                if (accept && (addr_q == LAST_ADDR)) begin
                    rd_d    = 1'b0;
                    state_d = DRAIN;
                end else begin
                    rd_d = (pend_nx < PEND_MAX);
                end
            end
            DRAIN: begin
                if (pend_q == '0)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef FB_CHECK_CAPTURE_EN
    always_comb begin
        fe_v_d   = fe_v_q;
        fe_a_d   = fe_a_q;
        fe_dat_d = fe_dat_q;
        if (start) begin
            fe_v_d   = 1'b0;
            fe_a_d   = '0;
            fe_dat_d = '0;
        end else if (rvalid && mismatch && !fe_v_q) begin
            fe_v_d   = 1'b1;
            fe_a_d   = chk_q;
            fe_dat_d = avl_readdata;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            fe_v_q   <= 1'b0;
            fe_a_q   <= '0;
            fe_dat_q <= '0;
        end else begin
            fe_v_q   <= fe_v_d;
            fe_a_q   <= fe_a_d;
            fe_dat_q <= fe_dat_d;
        end
    end

    assign first_err_valid = fe_v_q;
    assign first_err_addr  = fe_a_q;
    assign first_err_data  = fe_dat_q;
`endif

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
            hist_q  <= 2'b11;
            trig_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            pend_q  <= '0;
            chk_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            trig_q  <= trig_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
        end
    end

    assign avl_address              = addr_q;
    assign avl_read                 = rd_q;
    assign avl_burstbegin           = rd_q;
    assign err_count                = err_q;
    assign c_state                  = state_q;
    assign drv_status_test_complete = (state_q == DONE);
    assign drv_status_pass          = (state_q == DONE) && (err_q == '0);

endmodule
